screen_switch: RTL

SCREEN_SWITCH -- requirements
Module: screen_switch

---
 rtl/screen_pkg.sv | 14 +
 rtl/key_debounce.sv | 53 +++++
 rtl/screen_switch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared state encodings and default timing constants for screen_switch.
package screen_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_START = 2'd0;
  localparam logic [STATE_W-1:0] S_PLAY  = 2'd1;
  localparam logic [STATE_W-1:0] S_OVER  = 2'd2;

  // 20 ms at 40 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 800000;
  localparam int BLINK_FRAMES_DEF    = 30;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser plus counting debouncer; one press pulse per accepted 1->0.
module key_debounce
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK_40M,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles that disagree with the accepted level; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/screen_switch.sv
// rtl/screen_switch.sv - start/play/over screen FSM with frame-aligned, registered VGA source mux.
// Define OVER_BLINK_EN to blank the colours in alternating frame groups while in S_OVER.
module screen_switch
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_FRAMES    = BLINK_FRAMES_DEF
) (
  input  logic               CLK_40M,
  input  logic               RST,
  input  logic               key_start_n,
  input  logic               game_over,
  input  logic               start_Vga_red,
  input  logic               start_Vga_green,
  input  logic               start_Vga_blue,
  input  logic               start_Hsync_sig,
  input  logic               start_Vsync_sig,
  input  logic               game_Vga_red,
  input  logic               game_Vga_green,
  input  logic               game_Vga_blue,
  input  logic               game_Hsync_sig,
  input  logic               game_Vsync_sig,
  output logic               Vga_red,
  output logic               Vga_green,
  output logic               Vga_blue,
  output logic               Hsync_sig,
  output logic               Vsync_sig,
  output logic               game_en,
  output logic [STATE_W-1:0] screen_state
);

  if (DEBOUNCE_CYCLES < 1 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("screen_switch: DEBOUNCE_CYCLES and BLINK_FRAMES must be at least 1");
  end

  logic               press;
  logic [STATE_W-1:0] state_q, state_d;
  logic               sel_q, sel_d;
  logic               vs_prev_q;
  logic               frame_tick;
  logic               blank;
  logic               red_q, green_q, blue_q, hs_q, vs_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .CLK_40M(CLK_40M),
    .RST    (RST),
    .key_n  (key_start_n),
    .press  (press)
  );

  assign frame_tick = vs_prev_q & ~start_Vsync_sig;

  // game_over is checked before press so a collision always wins in S_PLAY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (press)     state_d = S_PLAY;
      S_PLAY:  if (game_over) state_d = S_OVER;
      S_OVER:  if (press)     state_d = S_START;
      default:                state_d = S_START;
    endcase
  end

  // Source only changes at a frame boundary so a frame is never torn between streams.
  assign sel_d = frame_tick ? (state_q == S_PLAY) : sel_q;

`ifdef OVER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  always_ff @(posedge CLK_40M) begin
    if (RST || (state_d == S_OVER && state_q != S_OVER)) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_q == S_OVER && frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign blank = (state_q == S_OVER) & blink_q;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      state_q   <= S_START;
      sel_q     <= 1'b0;
      vs_prev_q <= 1'b0;
      red_q     <= 1'b0;
      green_q   <= 1'b0;
      blue_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      vs_prev_q <= start_Vsync_sig;
      red_q     <= (sel_d ? game_Vga_red   : start_Vga_red)   & ~blank;
      green_q   <= (sel_d ? game_Vga_green : start_Vga_green) & ~blank;
      blue_q    <= (sel_d ? game_Vga_blue  : start_Vga_blue)  & ~blank;
      hs_q      <= sel_d ? game_Hsync_sig : start_Hsync_sig;
      vs_q      <= sel_d ? game_Vsync_sig : start_Vsync_sig;
    end
  end

  assign Vga_red      = red_q;
  assign Vga_green    = green_q;
  assign Vga_blue     = blue_q;
  assign Hsync_sig    = hs_q;
  assign Vsync_sig    = vs_q;
  assign game_en      = (state_q == S_PLAY) & sel_q;
  assign screen_state = state_q;

endmodule
